// File: rtl/clk_ratio_detector.sv
// rtl/clk_ratio_detector.sv - measures fast edges per slow period and decodes the programming code
// Optional feature macro: CMP_EXPECTED_EN (adds prog_exp input and mismatch output).
module clk_ratio_detector #(
  parameter int LOCK_CNT = 2,
  parameter int TIMEOUT  = 300
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fast_in,
  input  logic       slow_in,
  output logic [2:0] prog_det,
  output logic       locked,
  output logic [8:0] period,
  output logic       meas_valid,
  output logic       err,
  output logic       timeout
`ifdef CMP_EXPECTED_EN
  ,
  input  logic [2:0] prog_exp,
  output logic       mismatch
`endif
);

  localparam logic [2:0] LOCK_N = 3'(LOCK_CNT);
  localparam logic [8:0] TO_N   = 9'(TIMEOUT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MEAS = 2'd1
  } state_t;

  state_t     state;
  logic [2:0] fast_sync;
  logic [2:0] slow_sync;
  logic       fast_rise;
  logic       slow_rise;
  logic [8:0] cnt;
  logic [8:0] measured;
  logic       legal;
  logic [2:0] cand;
  logic [2:0] prev_code;
  logic [2:0] match;
  logic [2:0] match_next;

  // Two synchroniser flops plus one history flop per asynchronous input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fast_sync <= 3'b000;
      slow_sync <= 3'b000;
    end else begin
      fast_sync <= {fast_sync[1:0], fast_in};
      slow_sync <= {slow_sync[1:0], slow_in};
    end
  end

  assign fast_rise = fast_sync[1] & ~fast_sync[2];
  assign slow_rise = slow_sync[1] & ~slow_sync[2];

  // A fast edge coinciding with the closing slow edge belongs to this window.
  assign measured = cnt + {8'd0, fast_rise};

  // Decode the measured count; only exact powers of two from 2 to 256 are legal.
  always_comb begin
    legal = 1'b1;
    cand  = 3'd0;
    case (measured)
      9'd2:    cand = 3'd0;
      9'd4:    cand = 3'd1;
      9'd8:    cand = 3'd2;
      9'd16:   cand = 3'd3;
      9'd32:   cand = 3'd4;
      9'd64:   cand = 3'd5;
      9'd128:  cand = 3'd6;
      9'd256:  cand = 3'd7;
      default: legal = 1'b0;
    endcase
  end

  // Next value of the consecutive-match counter, saturating at the lock threshold.
  always_comb begin
    match_next = 3'd1;
    if (cand == prev_code) begin
      if (match >= LOCK_N) begin
        match_next = LOCK_N;
      end else begin
        match_next = match + 3'd1;
      end
    end
  end

  // Measurement FSM; evaluation happens in the cycle of the closing slow edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 9'd0;
      prog_det   <= 3'd0;
      locked     <= 1'b0;
      period     <= 9'd0;
      meas_valid <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
      prev_code  <= 3'd0;
      match      <= 3'd0;
    end else begin
      meas_valid <= 1'b0;
      err        <= 1'b0;
      timeout    <= 1'b0;
      case (state)
        IDLE: begin
          // The opening slow edge starts a window; a coincident fast edge is not counted.
          if (slow_rise) begin
            cnt   <= 9'd0;
            state <= MEAS;
          end
        end
        MEAS: begin
          if (slow_rise) begin
            period     <= measured;
            meas_valid <= 1'b1;
            cnt        <= 9'd0;
            if (legal) begin
              prev_code <= cand;
              match     <= match_next;
              if (match_next == LOCK_N) begin
                locked   <= 1'b1;
                prog_det <= cand;
              end else begin
                locked <= 1'b0;
              end
            end else begin
              err    <= 1'b1;
              locked <= 1'b0;
              match  <= 3'd0;
            end
          end else if (cnt == TO_N) begin
            // Slow clock has stalled: abandon the window and wait for a fresh edge.
            timeout <= 1'b1;
            locked  <= 1'b0;
            match   <= 3'd0;
            cnt     <= 9'd0;
            state   <= IDLE;
          end else if (fast_rise) begin
            cnt <= cnt + 9'd1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= 9'd0;
        end
      endcase
    end
  end

`ifdef CMP_EXPECTED_EN
  // Flag a locked code that disagrees with the generator's reported code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch <= 1'b0;
    end else begin
      mismatch <= locked & (prog_det != prog_exp);
    end
  end
`endif

endmodule

// File: doc/clk_ratio_detector.md
Name: clk_ratio_detector

Overview:
- Receiving end of the programmable clock generator's fast/slow clock pair.
- Samples the fast tick (10 Hz clock) and the programmable slow clock in the clk (100 MHz) domain and counts fast rising edges per slow period.
- Decodes that count back into the 3-bit programming code (period = 2^(code+1) fast periods) and reports code, lock status and errors.
- Used to confirm that an update request actually took effect at the slow clock.

Parameters:
- LOCK_CNT, 2, number of consecutive identical valid measurements required to assert locked (range 1..7).
- TIMEOUT, 300, fast rising edges without a slow rising edge before the measurement is aborted (range 257..511).

Ports:
- clk  input  1  system clock, 100 MHz.
- rst  input  1  asynchronous reset, active-high.
- fast_in  input  1  fast clock from the generator; asynchronous to clk.
- slow_in  input  1  programmable slow clock from the generator; asynchronous to clk.
- prog_det  output  3  decoded programming code of the slow clock; valid while locked=1.
- locked  output  1  high while LOCK_CNT consecutive equal valid measurements have been seen.
- period  output  9  last measured fast-edge count per slow period.
- meas_valid  output  1  one-clk pulse when period updates.
- err  output  1  one-clk pulse when the measured count is not a legal value.
- timeout  output  1  one-clk pulse when a measurement is aborted.

Behaviour:
- Reset: prog_det=0, locked=0, period=0, meas_valid=0, err=0, timeout=0; counters cleared; FSM in IDLE. Reset is asynchronous and aborts any measurement in progress.
- Input synchronisation:
  - Each input passes through two flops, then a third flop for edge detection.
  - rise_x = s2 & ~s3.
  - All registered outputs reflect an input rise 3 clk after the input changes.
- FSM states:
  - IDLE: wait for slow_rise; then cnt=0 and go to MEAS.
  - MEAS: count fast_rise; on slow_rise, go to EVAL.
  - EVAL: performed in the same cycle as the slow_rise and registered, then return to MEAS with cnt=0.
  - On timeout, go to IDLE.
- Counting:
  - The window is (previous slow rise, current slow rise].
  - A fast_rise coincident with the closing slow_rise is counted; a fast_rise coincident with the opening slow_rise is not. Hence a clean generator yields exactly N = 2^(code+1).
  - Measured value = cnt + fast_rise (9-bit).
- Evaluation:
  - period <= measured value and meas_valid pulses.
  - Legal values are 2, 4, 8, 16, 32, 64, 128 and 256, decoding to code 0..7.
  - Any other value: err pulses, locked <= 0, and the match counter clears.
- Lock:
  - Candidate code = decoded value.
  - Candidate equal to the previous candidate: match counter increments, saturating at LOCK_CNT. Otherwise the match counter resets to 1.
  - When the match counter reaches LOCK_CNT: locked <= 1 and prog_det <= candidate.
  - A different legal code while locked: locked <= 0, and prog_det holds its old value until relocked.
- Timeout:
  - In MEAS, if cnt reaches TIMEOUT: timeout pulses, locked <= 0, match counter clears, and the FSM goes to IDLE.
  - The counter never wraps.
- Simultaneous events:
  - If slow_rise and the timeout condition occur in the same cycle, slow_rise wins.
  - fast_rise in IDLE is ignored.
- Glitch-free requirement: inputs held constant produce no pulses at all (timeout only applies after the first slow edge).

Optional Feature:
- Macro CMP_EXPECTED_EN.
- With the macro defined:
  - Adds input prog_exp[2:0] (the generator's reported code) and output mismatch (1 bit, reset 0).
  - mismatch is registered and equals locked & (prog_det != prog_exp).
  - prog_exp is sampled in the clk domain without synchronisers; it must be quasi-static.
- Without the macro: no prog_exp or mismatch ports, and no comparison logic.

Test Plan:
- Reset then code 0 (slow period = 2 fast periods), LOCK_CNT=2 -> period=2 with meas_valid each slow rise; locked=1 and prog_det=0 after the 2nd measurement.
- Code switched from 0 to 5 while locked -> first period=64 measurement drops locked; locked=1, prog_det=5 after the second 64.
- Code 7 -> period=256 and prog_det=7 with no timeout; stop slow_in with fast running -> timeout pulse at cnt=300, locked=0, FSM back to IDLE, then recovery on the next slow edges.
- Inject a slow period of 3 fast edges -> period=3, err pulse, locked=0; two further clean periods of 8 -> locked=1, prog_det=2.
- Assert rst mid-measurement at code 4 -> all outputs 0 immediately; locked reasserts after LOCK_CNT+1 slow rises.
- CMP_EXPECTED_EN: lock on code 3 with prog_exp=3 -> mismatch=0; set prog_exp=6 -> mismatch=1 on the next clk.
